// File: rtl/gcttt_pkg.sv
// Shared constants and types for the grid cursor controller and its grid-side peers.
package gcttt_pkg;

  localparam int GRID_N    = 3;
  localparam int COORD_W   = 4;
  localparam int NUM_CELLS = GRID_N * GRID_N;

  localparam logic [COORD_W-1:0] CELL_FIRST = 4'd0;
  localparam logic [COORD_W-1:0] CELL_LAST  = 4'd8;

  // Button vector layout: a higher bit index means a higher priority
  localparam int BTN_W     = 5;
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_SEL   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } gc_state_e;

endpackage

// File: rtl/grid_cursor_ctrl_if.sv
// Write port between the cursor controller (master) and the grid coordinate register (slave).
interface grid_cursor_ctrl_if #(
  parameter int GRID_N  = gcttt_pkg::GRID_N,
  parameter int COORD_W = gcttt_pkg::COORD_W
);

  logic [COORD_W-1:0]       coord_out;
  logic                     write_en;
  logic                     reject;
  logic [GRID_N*GRID_N-1:0] occ_mask;

  modport master (
    output coord_out,
    output write_en,
    output reject,
    input  occ_mask
  );

  modport slave (
    input  coord_out,
    input  write_en,
    input  reject,
    output occ_mask
  );

endinterface

// File: rtl/btn_edge.sv
// N-bit registered rising-edge detector; history resets to all-ones so a
// level held high through reset never produces an event.
module btn_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_r;
  logic [N-1:0] rise_r;

  // Sample history and register the one-cycle rise pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= {N{1'b1}};
      rise_r <= {N{1'b0}};
    end else begin
      prev_r <= din;
      rise_r <= din & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Turns debounced button presses into a grid cursor and issues one guarded
// write per select into the grid coordinate register.
module grid_cursor_ctrl #(
  parameter int GRID_N      = gcttt_pkg::GRID_N,
  parameter int COORD_W     = gcttt_pkg::COORD_W,
  parameter bit WRAP        = 1'b1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_sel,
  grid_cursor_ctrl_if.master  wr,
  output logic [1:0]          cursor_row,
  output logic [1:0]          cursor_col
);

  import gcttt_pkg::*;

  localparam logic [1:0] EDGE_MAX  = 2'(GRID_N - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  logic [BTN_W-1:0]   btn_s;
  logic [BTN_W-1:0]   rise_s;
  logic [1:0]         row_nxt_s;
  logic [1:0]         col_nxt_s;
  logic [COORD_W-1:0] coord_nxt_s;
  logic               move_s;
  logic               occ_hit_s;

  gc_state_e          state_r;
  logic [1:0]         row_r;
  logic [1:0]         col_r;
  logic [COORD_W-1:0] coord_r;
  logic               write_en_r;
  logic               reject_r;
  logic [7:0]         hold_cnt_r;

  assign btn_s = {btn_sel, btn_up, btn_down, btn_left, btn_right};

  btn_edge #(.N(BTN_W)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_s),
    .rise (rise_s)
  );

  // Next cursor position from the highest-priority move event
  always_comb begin
    row_nxt_s = row_r;
    col_nxt_s = col_r;
    move_s    = 1'b1;
    if (rise_s[BTN_UP]) begin
      if (row_r == 2'd0) begin
        row_nxt_s = WRAP ? EDGE_MAX : 2'd0;
      end else begin
        row_nxt_s = row_r - 2'd1;
      end
    end else if (rise_s[BTN_DOWN]) begin
      if (row_r == EDGE_MAX) begin
        row_nxt_s = WRAP ? 2'd0 : EDGE_MAX;
      end else begin
        row_nxt_s = row_r + 2'd1;
      end
    end else if (rise_s[BTN_LEFT]) begin
      if (col_r == 2'd0) begin
        col_nxt_s = WRAP ? EDGE_MAX : 2'd0;
      end else begin
        col_nxt_s = col_r - 2'd1;
      end
    end else if (rise_s[BTN_RIGHT]) begin
      if (col_r == EDGE_MAX) begin
        col_nxt_s = WRAP ? 2'd0 : EDGE_MAX;
      end else begin
        col_nxt_s = col_r + 2'd1;
      end
    end else begin
      move_s = 1'b0;
    end
  end

  assign coord_nxt_s = COORD_W'(row_nxt_s) * COORD_W'(GRID_N) + COORD_W'(col_nxt_s);
  assign occ_hit_s   = wr.occ_mask[coord_r];

  // Control FSM; a select outranks any move seen in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      row_r      <= 2'd0;
      col_r      <= 2'd0;
      coord_r    <= {COORD_W{1'b0}};
      write_en_r <= 1'b0;
      reject_r   <= 1'b0;
      hold_cnt_r <= 8'd0;
    end else begin
      write_en_r <= 1'b0;
      reject_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          if (!enable) begin
            state_r <= IDLE;
          end else if (rise_s[BTN_SEL]) begin
            if (occ_hit_s) begin
              reject_r <= 1'b1;
            end else begin
              state_r    <= COMMIT;
              write_en_r <= 1'b1;
            end
          end else if (move_s) begin
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
            coord_r <= coord_nxt_s;
          end else begin
            state_r <= ARMED;
          end
        end
        COMMIT: begin
          state_r    <= HOLD;
          hold_cnt_r <= HOLD_LOAD;
        end
        HOLD: begin
          if (hold_cnt_r == 8'd0) begin
            state_r <= enable ? ARMED : IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign wr.coord_out = coord_r;
  assign wr.write_en  = write_en_r;
  assign wr.reject    = reject_r;
  assign cursor_row   = row_r;
  assign cursor_col   = col_r;

endmodule
